sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM bridge slave of the SDRAM controller between two RISC-V core masters: m0 (instruction fetch) and m1 (data load/store).
- Serialises single-beat transfers, one granted master at a time.
- Tracks outstanding reads in an ID FIFO so each returning readdatavalid is routed to the master that issued the read.
- Sits between the core memory interface and the controller's mm_bridge_s_* port.

Parameters:
- ADDR_W, 27, word-address width, matches mm_bridge_s_address.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_PENDING, 4, depth of the outstanding-read ID FIFO; power of 2, at least 2.

Ports:
- clk_clk  in  1  system clock; all logic is rising-edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- m0_address/m1_address  in  ADDR_W  master address.
- m0_read/m1_read, m0_write/m1_write  in  1  request strobes, held until accepted.
- m0_writedata/m1_writedata  in  DATA_W  write data.
- m0_byteenable/m1_byteenable  in  DATA_W/8  byte lanes.
- m0_waitrequest/m1_waitrequest  out  1  stall to the master.
- m0_readdata/m1_readdata  out  DATA_W  read return data.
- m0_readdatavalid/m1_readdatavalid  out  1  read return strobe.
- mm_bridge_s_address  out  ADDR_W; mm_bridge_s_writedata  out  DATA_W; mm_bridge_s_byteenable  out  DATA_W/8.
- mm_bridge_s_read/mm_bridge_s_write  out  1; mm_bridge_s_burstcount  out  1 (constant 1); mm_bridge_s_debugaccess  out  1 (constant 0).
- mm_bridge_s_waitrequest  in  1; mm_bridge_s_readdata  in  DATA_W; mm_bridge_s_readdatavalid  in  1.
- rd_orphan  out  1  sticky error: readdatavalid arrived with no pending read.

Behaviour:
- Reset values:
  - state=ARB, FIFO empty, last_grant=m1, rd_orphan=0.
  - mm_bridge_s_read/write=0, address/writedata/byteenable=0.
  - m0/m1_waitrequest=1, m0/m1_readdatavalid=0.
- Request definition: req_x = mx_read | mx_write. A read request is eligible only while the FIFO is not full; a write is always eligible.
- State machine: ARB, BUSY0, BUSY1.
  - ARB:
    - Bridge read/write driven 0; both master waitrequests 1.
    - If any eligible request exists, register the winner and go to BUSYx next cycle. Otherwise stay in ARB.
    - Fixed priority: m1 wins over m0.
  - BUSYx:
    - Bridge address, writedata, byteenable, read and write are combinational copies of mx.
    - mx_waitrequest = mm_bridge_s_waitrequest; the other master's waitrequest = 1.
    - Acceptance (mx read or write asserted AND mm_bridge_s_waitrequest=0): return to ARB next cycle.
    - If mx drops both strobes (protocol violation): return to ARB and issue nothing.
  - Minimum cost is 2 cycles per transfer (ARB plus accept cycle). No transfer is issued in ARB.
- Read ID FIFO:
  - Width 1, depth MAX_PENDING.
  - Push grant ID on a read acceptance.
  - Pop on mm_bridge_s_readdatavalid.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Full: no new read is granted; a pending write from either master may still be granted.
- Return path:
  - m0_readdata = m1_readdata = mm_bridge_s_readdata (combinational broadcast).
  - mx_readdatavalid = mm_bridge_s_readdatavalid & FIFO non-empty & head==x.
  - readdatavalid with the FIFO empty: dropped (neither master sees it) and rd_orphan set until reset.
- Ordering: the controller returns reads in order, so FIFO order equals return order. Writes produce no response.
- Reset mid-operation: all state clears immediately. Returns still in flight are orphaned after reset and set rd_orphan; software clears by reset only.

Optional Feature:
- Macro: SDRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - last_grant is updated on every ARB grant.
  - When both masters have eligible requests, the master not equal to last_grant wins.
  - A single requester wins regardless of last_grant.
- Undefined: fixed priority m1 > m0; last_grant is unused and optimised away.

Test Plan:
- Single m0 read, addr 0x0000100, bridge waitrequest=0, readdatavalid 3 cycles later with data 0xDEADBEEF -> bridge read seen exactly 1 cycle, m0_readdatavalid=1 with 0xDEADBEEF, m1_readdatavalid stays 0.
- m0 and m1 both read in the same cycle, feature off -> m1 granted first, m0 next; returns 0x11111111 then 0x22222222 go to m1 then m0.
- Same as previous with SDRAM_ARB_ROUND_ROBIN_EN, 6 back-to-back request pairs -> grants alternate m1, m0, m1, m0 ...
- MAX_PENDING=4, m1 issues 4 reads with no returns, then m0 write 0xCAFEF00D, byteenable 0xF -> write accepted, 5th read stalled (m1_waitrequest=1) until the first readdatavalid, then granted.
- Bridge waitrequest held 5 cycles during an m1 write -> bridge address/data stable, m1_waitrequest=1 for 5 cycles, m0_waitrequest=1 throughout.
- Reset asserted with 2 reads pending, then 2 readdatavalid pulses after reset -> no master readdatavalid, rd_orphan=1.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the SDRAM controller's single Avalon-MM bridge slave between two core masters:
//   m0 (instruction fetch) and m1 (data load/store). One single-beat transfer is in flight
//   on the request side at a time. The ID of every accepted read is queued, so each
//   returning readdatavalid is routed back to the master that issued that read.
//
//   Optional feature, macro SDRAM_ARB_ROUND_ROBIN_EN:
//     defined   - contested grants alternate, using the last granted master
//     undefined - fixed priority, m1 over m0
//
// Ports
//   clk_clk, reset_reset_n        clock, asynchronous active-low reset
//   m0_* / m1_*                   master slave-side ports (address, read, write, writedata,
//                                 byteenable in; waitrequest, readdata, readdatavalid out)
//   mm_bridge_s_*                 controller bridge slave (request out, response in)
//   rd_orphan                     sticky: readdatavalid arrived with no read pending
module sdram_port_arbiter #(
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mm_bridge_s_address,
   output logic [DATA_W-1:0]     mm_bridge_s_writedata,
   output logic [DATA_W/8-1:0]   mm_bridge_s_byteenable,
   output logic                  mm_bridge_s_read,
   output logic                  mm_bridge_s_write,
   output logic                  mm_bridge_s_burstcount,
   output logic                  mm_bridge_s_debugaccess,
   input  logic                  mm_bridge_s_waitrequest,
   input  logic [DATA_W-1:0]     mm_bridge_s_readdata,
   input  logic                  mm_bridge_s_readdatavalid,
   output logic                  rd_orphan
);

   localparam int unsigned PtrW = $clog2(MAX_PENDING);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(MAX_PENDING);

   typedef enum logic [1:0] {StArb, StBusy0, StBusy1} state_t;

   state_t                 state;
   logic [MAX_PENDING-1:0] id_mem;   // 1 = read issued by m1
   logic [PtrW-1:0]        wr_ptr;
   logic [PtrW-1:0]        rd_ptr;
   logic [PtrW:0]          count;

   logic fifo_full, fifo_empty, head_id;
   logic req0, req1, elig0, elig1;
   logic accept0, accept1, push, pop, grant1;

   assign fifo_full  = (count == FullCnt);
   assign fifo_empty = (count == '0);
   assign head_id    = id_mem[rd_ptr];

   assign req0  = m0_read | m0_write;
   assign req1  = m1_read | m1_write;
   // A read may only be granted while there is room to remember who issued it.
   assign elig0 = m0_write | (m0_read & ~fifo_full);
   assign elig1 = m1_write | (m1_read & ~fifo_full);

   assign accept0 = (state == StBusy0) & req0 & ~mm_bridge_s_waitrequest;
   assign accept1 = (state == StBusy1) & req1 & ~mm_bridge_s_waitrequest;
   assign pop     = mm_bridge_s_readdatavalid & ~fifo_empty;
   assign push    = ((accept0 & m0_read) | (accept1 & m1_read)) & (~fifo_full | pop);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   logic last_grant;   // 1 = m1 was granted last

   assign grant1 = (elig0 & elig1) ? ~last_grant : elig1;
`else
   assign grant1 = elig1;
`endif

   // Bridge request is a straight copy of the owning master; idle drives zeros.
   always_comb begin
      mm_bridge_s_address    = '0;
      mm_bridge_s_writedata  = '0;
      mm_bridge_s_byteenable = '0;
      mm_bridge_s_read       = 1'b0;
      mm_bridge_s_write      = 1'b0;
      m0_waitrequest         = 1'b1;
      m1_waitrequest         = 1'b1;
      case (state)
         StBusy0: begin
            mm_bridge_s_address    = m0_address;
            mm_bridge_s_writedata  = m0_writedata;
            mm_bridge_s_byteenable = m0_byteenable;
            mm_bridge_s_read       = m0_read;
            mm_bridge_s_write      = m0_write;
            m0_waitrequest         = mm_bridge_s_waitrequest;
         end
         StBusy1: begin
            mm_bridge_s_address    = m1_address;
            mm_bridge_s_writedata  = m1_writedata;
            mm_bridge_s_byteenable = m1_byteenable;
            mm_bridge_s_read       = m1_read;
            mm_bridge_s_write      = m1_write;
            m1_waitrequest         = mm_bridge_s_waitrequest;
         end
         default: ;
      endcase
   end

   assign mm_bridge_s_burstcount  = 1'b1;
   assign mm_bridge_s_debugaccess = 1'b0;

   assign m0_readdata      = mm_bridge_s_readdata;
   assign m1_readdata      = mm_bridge_s_readdata;
   assign m0_readdatavalid = pop & ~head_id;
   assign m1_readdatavalid = pop & head_id;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state     <= StArb;
         id_mem    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_orphan <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            StArb: begin
               if (elig0 | elig1) begin
                  state <= grant1 ? StBusy1 : StBusy0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                  last_grant <= grant1;
`endif
               end
            end
            // Leave on acceptance, or when the master abandons its strobes.
            StBusy0: if (!req0 || !mm_bridge_s_waitrequest) state <= StArb;
            StBusy1: if (!req1 || !mm_bridge_s_waitrequest) state <= StArb;
            default: state <= StArb;
         endcase

         if (push) begin
            id_mem[wr_ptr] <= (state == StBusy1);
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         if (mm_bridge_s_readdatavalid && fifo_empty) rd_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed scenarios plus randomized traffic, each cycle compared
// against a transaction-level model (owner of the bus, queue of pending read owners).
module tb_sdram_port_arbiter;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;
   localparam int MP = 4;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   typedef struct packed {
      logic          wr0, wr1, rdv0, rdv1;
      logic [DW-1:0] rd0, rd1;
      logic          brd, bwr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [BW-1:0] be;
      logic          bc, dbg, orphan;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] a_addr [2];
   logic          a_rd   [2];
   logic          a_wr   [2];
   logic [DW-1:0] a_wd   [2];
   logic [BW-1:0] a_be   [2];
   logic          br_wait, br_rdv;
   logic [DW-1:0] br_rdata;

   logic          m0_wr, m1_wr, m0_rdv, m1_rdv, brd, bwr, bbc, bdbg, orphan;
   logic [DW-1:0] m0_rd, m1_rd, bwd;
   logic [AW-1:0] baddr;
   logic [BW-1:0] bbe;

   sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
      .clk_clk                  (clk),
      .reset_reset_n            (rst_n),
      .m0_address               (a_addr[0]),
      .m0_read                  (a_rd[0]),
      .m0_write                 (a_wr[0]),
      .m0_writedata             (a_wd[0]),
      .m0_byteenable            (a_be[0]),
      .m0_waitrequest           (m0_wr),
      .m0_readdata              (m0_rd),
      .m0_readdatavalid         (m0_rdv),
      .m1_address               (a_addr[1]),
      .m1_read                  (a_rd[1]),
      .m1_write                 (a_wr[1]),
      .m1_writedata             (a_wd[1]),
      .m1_byteenable            (a_be[1]),
      .m1_waitrequest           (m1_wr),
      .m1_readdata              (m1_rd),
      .m1_readdatavalid         (m1_rdv),
      .mm_bridge_s_address      (baddr),
      .mm_bridge_s_writedata    (bwd),
      .mm_bridge_s_byteenable   (bbe),
      .mm_bridge_s_read         (brd),
      .mm_bridge_s_write        (bwr),
      .mm_bridge_s_burstcount   (bbc),
      .mm_bridge_s_debugaccess  (bdbg),
      .mm_bridge_s_waitrequest  (br_wait),
      .mm_bridge_s_readdata     (br_rdata),
      .mm_bridge_s_readdatavalid(br_rdv),
      .rd_orphan                (orphan)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus (-1 none), which masters await read data, in order.
   int owner;
   int q[$];
   bit orph;
   bit last1;
   bit acc [2];

   task automatic model_reset();
      owner = -1;
      q.delete();
      orph = 1'b0;
      last1 = 1'b1;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
   endtask

   task automatic model_step(output obs_t e);
      bit el0, el1, do_push;
      int nxt, pid;
      e = '0;
      e.wr0 = 1'b1;
      e.wr1 = 1'b1;
      e.rd0 = br_rdata;
      e.rd1 = br_rdata;
      e.bc = 1'b1;
      e.orphan = orph;
      acc[0] = 1'b0;
      acc[1] = 1'b0;
      if (!rst_n) begin
         model_reset();
         e.orphan = 1'b0;
         return;
      end
      do_push = 1'b0;
      pid = owner;
      nxt = owner;
      el0 = a_wr[0] | (a_rd[0] & (q.size() < MP));
      el1 = a_wr[1] | (a_rd[1] & (q.size() < MP));
      if (owner < 0) begin
         if (el0 && el1) nxt = RrEn ? (last1 ? 0 : 1) : 1;
         else if (el1) nxt = 1;
         else if (el0) nxt = 0;
         if (nxt >= 0) last1 = (nxt == 1);
      end else begin
         e.brd = a_rd[owner];
         e.bwr = a_wr[owner];
         e.addr = a_addr[owner];
         e.wd = a_wd[owner];
         e.be = a_be[owner];
         if (owner == 0) e.wr0 = br_wait;
         else e.wr1 = br_wait;
         if (!(a_rd[owner] | a_wr[owner])) nxt = -1;
         else if (!br_wait) begin
            acc[owner] = 1'b1;
            nxt = -1;
            do_push = a_rd[owner];
         end
      end
      if (br_rdv) begin
         if (q.size() > 0) begin
            if (q[0] == 0) e.rdv0 = 1'b1;
            else e.rdv1 = 1'b1;
            void'(q.pop_front());
         end else begin
            orph = 1'b1;
         end
      end
      if (do_push) q.push_back(pid);
      owner = nxt;
   endtask

   task automatic settle(output obs_t e, output obs_t o);
      #1;
      model_step(e);
      o = {m0_wr, m1_wr, m0_rdv, m1_rdv, m0_rd, m1_rd, brd, bwr, baddr, bwd, bbe, bbc, bdbg,
           orphan};
   endtask

   // Advance one clock; masters drop strobes once accepted, readdatavalid is a pulse.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int x = 0; x < 2; x++) begin
         if (acc[x]) begin
            a_rd[x] = 1'b0;
            a_wr[x] = 1'b0;
         end
      end
      br_rdv = 1'b0;
   endtask

   task automatic test_reset();
      obs_t e, o;
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset cyc %0d got %h exp %h", c, o, e);
         end
         tick();
      end
      rst_n = 1'b1;
      settle(e, o);
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_release got %h exp %h", o, e);
      end
      tick();
   endtask

   task automatic test_single_read();
      obs_t e, o;
      int nrd = 0;
      bit got = 1'b0, m1seen = 1'b0;
      a_addr[0] = 27'h0000100;
      a_be[0] = 4'hF;
      a_rd[0] = 1'b1;
      br_wait = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c == 4) begin
            br_rdv = 1'b1;
            br_rdata = 32'hDEADBEEF;
         end
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL single_read cyc %0d got %h exp %h", c, o, e);
         end
         if (o.brd) nrd++;
         if (o.rdv0 && o.rd0 === 32'hDEADBEEF) got = 1'b1;
         if (o.rdv1) m1seen = 1'b1;
         tick();
      end
      checks++;
      if (nrd != 1 || !got || m1seen) begin
         errors++;
         $display("FAIL single_read_summary read_cycles %0d m0_data %0b m1_rdv %0b need 1 1 0",
                  nrd, got, m1seen);
      end
   endtask

   task automatic test_both_read();
      obs_t e, o;
      int g[$];
      int gsig;
      logic [DW-1:0] d0 = '0, d1 = '0;
      a_addr[0] = 27'h0000200;
      a_addr[1] = 27'h0000300;
      a_rd[0] = 1'b1;
      a_rd[1] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) begin br_rdv = 1'b1; br_rdata = 32'h11111111; end
         if (c == 6) begin br_rdv = 1'b1; br_rdata = 32'h22222222; end
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL both_read cyc %0d got %h exp %h", c, o, e);
         end
         if (o.brd && !o.wr1) g.push_back(1);
         else if (o.brd && !o.wr0) g.push_back(0);
         if (o.rdv0) d0 = o.rd0;
         if (o.rdv1) d1 = o.rd1;
         tick();
      end
      gsig = (g.size() == 2) ? g[0] * 10 + g[1] : -1;
      checks++;
      if (gsig != 10) begin
         errors++;
         $display("FAIL both_read_order got %0d need 10 (m1 then m0)", gsig);
      end
      checks++;
      if (d1 !== 32'h11111111 || d0 !== 32'h22222222) begin
         errors++;
         $display("FAIL both_read_route m1 %h m0 %h need 11111111 22222222", d1, d0);
      end
   endtask

   task automatic test_back_to_back();
      obs_t e, o;
      int g[$];
      int c = 0;
      for (int x = 0; x < 2; x++) begin
         a_wr[x] = 1'b1;
         a_addr[x] = AW'($urandom);
         a_wd[x] = $urandom;
         a_be[x] = BW'($urandom);
      end
      while (g.size() < 12 && c < 80) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back cyc %0d got %h exp %h", c, o, e);
         end
         if (o.bwr && !o.wr1) g.push_back(1);
         else if (o.bwr && !o.wr0) g.push_back(0);
         tick();
         if (g.size() < 12) begin
            for (int x = 0; x < 2; x++) begin
               if (!a_wr[x]) begin
                  a_wr[x] = 1'b1;
                  a_addr[x] = AW'($urandom);
                  a_wd[x] = $urandom;
               end
            end
         end
         c++;
      end
      checks++;
      if (g.size() != 12) begin
         errors++;
         $display("FAIL back_to_back_count got %0d grants need 12", g.size());
      end
      for (int i = 0; i < g.size(); i++) begin
         int want = RrEn ? ((i % 2 == 0) ? 1 : 0) : 1;
         checks++;
         if (g[i] != want) begin
            errors++;
            $display("FAIL back_to_back_grant %0d got m%0d need m%0d", i, g[i], want);
         end
      end
      // Let any still-waiting write complete.
      for (int d = 0; d < 6; d++) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back_drain cyc %0d got %h exp %h", d, o, e);
         end
         tick();
      end
   endtask

   task automatic test_fifo_full();
      obs_t e, o;
      int nacc = 0, nret = 0;
      bit wgot = 1'b0, leak = 1'b0, granted = 1'b0;
      a_rd[1] = 1'b1;
      a_addr[1] = AW'($urandom);
      for (int c = 0; c < 40 && nacc < 4; c++) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fifo_fill cyc %0d got %h exp %h", c, o, e);
         end
         if (o.brd && !o.wr1) nacc++;
         tick();
         if (!a_rd[1] && nacc < 4) begin
            a_rd[1] = 1'b1;
            a_addr[1] = AW'($urandom);
         end
      end
      checks++;
      if (nacc != 4) begin
         errors++;
         $display("FAIL fifo_fill_count got %0d need 4", nacc);
      end
      a_rd[1] = 1'b1;
      a_addr[1] = 27'h0000777;
      a_wr[0] = 1'b1;
      a_addr[0] = 27'h0000400;
      a_wd[0] = 32'hCAFEF00D;
      a_be[0] = 4'hF;
      for (int c = 0; c < 8; c++) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fifo_full_stall cyc %0d got %h exp %h", c, o, e);
         end
         if (o.bwr && !o.wr0 && o.wd === 32'hCAFEF00D && o.be === 4'hF) wgot = 1'b1;
         if (!o.wr1) leak = 1'b1;
         tick();
      end
      checks++;
      if (!wgot || leak) begin
         errors++;
         $display("FAIL fifo_full_write write_seen %0b read_leak %0b need 1 0", wgot, leak);
      end
      for (int c = 0; c < 10 && !granted; c++) begin
         if (c == 0) begin br_rdv = 1'b1; br_rdata = $urandom; end
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fifo_unblock cyc %0d got %h exp %h", c, o, e);
         end
         if (o.rdv1) nret++;
         if (o.brd && !o.wr1) granted = 1'b1;
         tick();
      end
      checks++;
      if (!granted) begin
         errors++;
         $display("FAIL fifo_unblock_grant got 0 need 1");
      end
      for (int c = 0; c < 4; c++) begin
         br_rdv = 1'b1;
         br_rdata = $urandom;
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fifo_drain cyc %0d got %h exp %h", c, o, e);
         end
         if (o.rdv1) nret++;
         tick();
      end
      checks++;
      if (nret != 5) begin
         errors++;
         $display("FAIL fifo_drain_count got %0d m1 returns need 5", nret);
      end
   endtask

   task automatic test_wait_hold();
      obs_t e, o;
      int nhold = 0;
      bit unstable = 1'b0, m0low = 1'b0;
      a_wr[1] = 1'b1;
      a_addr[1] = 27'h00ABCDE;
      a_wd[1] = 32'h5A5A1234;
      a_be[1] = 4'h3;
      br_wait = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c == 6) br_wait = 1'b0;
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wait_hold cyc %0d got %h exp %h", c, o, e);
         end
         if (o.bwr && o.wr1) nhold++;
         if (o.bwr && (o.addr !== 27'h00ABCDE || o.wd !== 32'h5A5A1234)) unstable = 1'b1;
         if (!o.wr0) m0low = 1'b1;
         tick();
      end
      checks++;
      if (nhold != 5 || unstable || m0low) begin
         errors++;
         $display("FAIL wait_hold_summary stall %0d unstable %0b m0_wr_low %0b need 5 0 0",
                  nhold, unstable, m0low);
      end
   endtask

   task automatic test_reset_orphan();
      obs_t e, o;
      bit leak = 1'b0;
      a_rd[0] = 1'b1;
      a_rd[1] = 1'b1;
      for (int c = 0; c < 10 && (a_rd[0] || a_rd[1]); c++) begin
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL orphan_issue cyc %0d got %h exp %h", c, o, e);
         end
         tick();
      end
      rst_n = 1'b0;
      a_rd[0] = 1'b0;
      a_rd[1] = 1'b0;
      settle(e, o);
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL orphan_in_reset got %h exp %h", o, e);
      end
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c < 2) begin br_rdv = 1'b1; br_rdata = $urandom; end
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL orphan_return cyc %0d got %h exp %h", c, o, e);
         end
         if (o.rdv0 || o.rdv1) leak = 1'b1;
         tick();
      end
      settle(e, o);
      checks++;
      if (leak || o.orphan !== 1'b1) begin
         errors++;
         $display("FAIL orphan_flag rdv_leak %0b rd_orphan %b need 0 1", leak, o.orphan);
      end
      tick();
   endtask

   task automatic test_random();
      obs_t e, o;
      rst_n = 1'b0;
      settle(e, o);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
         for (int x = 0; x < 2; x++) begin
            if (!a_rd[x] && !a_wr[x] && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 1) == 1) a_rd[x] = 1'b1;
               else a_wr[x] = 1'b1;
               a_addr[x] = AW'($urandom);
               a_wd[x] = $urandom;
               a_be[x] = BW'($urandom);
            end
         end
         br_wait = ($urandom_range(0, 3) == 0);
         if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
            br_rdv = 1'b1;
            br_rdata = $urandom;
         end
         settle(e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL random cyc %0d got %h exp %h", c, o, e);
         end
         tick();
      end
   endtask

   initial begin
      for (int x = 0; x < 2; x++) begin
         a_addr[x] = '0;
         a_rd[x] = 1'b0;
         a_wr[x] = 1'b0;
         a_wd[x] = '0;
         a_be[x] = '0;
      end
      br_wait = 1'b0;
      br_rdv = 1'b0;
      br_rdata = '0;
      model_reset();
      #1;
      test_reset();
      test_single_read();
      test_both_read();
      test_back_to_back();
      test_fifo_full();
      test_wait_hold();
      test_reset_orphan();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
